dac_segment_ctrl: RTL and testbench

Digital control stage directly upstream of the current-source unit array: turns a registered DAC code into per-unit switch selects for the 17 thermometer units, the 6 binary units and the redundant LSB unit. It also sequences the array's `pdb` power-up with a settling delay, applies data-weighted-averaging (DWA) rotation across the thermometer units and registers the analog-testbus select. Sits between the digital code source and the analog current-source unit block.

---
 rtl/dac_segment_ctrl.sv | 154 +++++++++++++++
 tb/tb_dac_segment_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/dac_segment_ctrl.sv
// Segment controller for the current-source unit array: power-up sequencing,
// code-to-unit mapping with DWA rotation of the thermometer units, testbus select.
module dac_segment_ctrl #(
   parameter int SETTLE_CYCLES = 16,
   parameter bit DEM_EN        = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic [10:0] code,
   input  logic        code_valid,
   output logic        code_ready,
   input  logic        red_sel,
   input  logic [1:0]  atb_ena_in,
   output logic        pdb,
   output logic [16:0] therm_sel,
   output logic [5:0]  bin_sel,
   output logic        bin0_red_sel,
   output logic [1:0]  atb_ena,
   output logic        dac_ready,
   output logic        sat
);

   localparam int          CNT_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [10:0] CODE_MAX = 11'd1151;

   typedef enum logic [1:0] {
      ST_OFF,
      ST_SETTLE,
      ST_ACTIVE
   } state_t;

   function automatic logic [10:0] sat_code(input logic [10:0] c);
      return (c > CODE_MAX) ? CODE_MAX : c;
   endfunction

   // n consecutive units starting at ptr, wrapping modulo 17
   function automatic logic [16:0] therm_mask(input logic [4:0] n, input logic [4:0] ptr);
      logic [17:0] ones;
      logic [33:0] dbl;
      ones = (18'd1 << n) - 18'd1;
      dbl  = {ones[16:0], ones[16:0]} >> (5'd17 - ptr);
      return dbl[16:0];
   endfunction

   function automatic logic [4:0] ptr_wrap(input logic [4:0] p, input logic [4:0] n);
      logic [5:0] s;
      s = {1'b0, p} + {1'b0, n};
      if (s >= 6'd17) s = s - 6'd17;
      return s[4:0];
   endfunction

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [4:0]       ptr_q, ptr_d;
   logic [16:0]      therm_q, therm_d;
   logic [5:0]       bin_q, bin_d;
   logic             red_q, red_d;
   logic             sat_q, sat_d;
   logic [1:0]       atb_q, atb_d;

   logic [10:0] code_c;
   logic [4:0]  n_w;
   logic [5:0]  b_w;
   logic        accept;

   assign code_c = sat_code(code);
   assign n_w    = code_c[10:6];
   assign b_w    = code_c[5:0];
   // ready is advertised in ACTIVE, but a cycle with enable low is never accepted
   assign accept = code_valid && (state_q == ST_ACTIVE) && enable;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ptr_d   = ptr_q;
      therm_d = therm_q;
      bin_d   = bin_q;
      red_d   = red_q;
      sat_d   = sat_q;
      atb_d   = (enable && (state_q != ST_OFF)) ? atb_ena_in : 2'b00;

      case (state_q)
         ST_OFF: begin
            if (enable) begin
               state_d = ST_SETTLE;
               cnt_d   = '0;
            end
         end
         ST_SETTLE: begin
            if (cnt_q == CNT_LAST) state_d = ST_ACTIVE;
            else                   cnt_d   = cnt_q + CNT_W'(1);
         end
         ST_ACTIVE: begin
            if (accept) begin
               sat_d = (code > CODE_MAX);
               bin_d = {b_w[5:1], red_sel ? 1'b0 : b_w[0]};
               red_d = red_sel & b_w[0];
               if (DEM_EN) begin
                  therm_d = therm_mask(n_w, ptr_q);
                  ptr_d   = ptr_wrap(ptr_q, n_w);
               end else begin
                  therm_d = therm_mask(n_w, 5'd0);
                  ptr_d   = 5'd0;
               end
            end
         end
         default: state_d = ST_OFF;
      endcase

      if (!enable) begin
         state_d = ST_OFF;
         cnt_d   = '0;
         ptr_d   = '0;
         therm_d = '0;
         bin_d   = '0;
         red_d   = 1'b0;
         sat_d   = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_OFF;
         cnt_q   <= '0;
         ptr_q   <= '0;
         therm_q <= '0;
         bin_q   <= '0;
         red_q   <= 1'b0;
         sat_q   <= 1'b0;
         atb_q   <= 2'b00;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ptr_q   <= ptr_d;
         therm_q <= therm_d;
         bin_q   <= bin_d;
         red_q   <= red_d;
         sat_q   <= sat_d;
         atb_q   <= atb_d;
      end
   end

   assign pdb          = (state_q != ST_OFF);
   assign code_ready   = (state_q == ST_ACTIVE);
   assign dac_ready    = (state_q == ST_ACTIVE);
   assign therm_sel    = therm_q;
   assign bin_sel      = bin_q;
   assign bin0_red_sel = red_q;
   assign sat          = sat_q;
   assign atb_ena      = atb_q;

endmodule

// File: tb/tb_dac_segment_ctrl.sv
// Bench for dac_segment_ctrl: directed scenarios plus randomized traffic checked
// against a behavioural model of power sequencing and unit selection.
module tb_dac_segment_ctrl;

   localparam int SETTLE = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        enable = 1'b0;
   logic [10:0] code = '0;
   logic        code_valid = 1'b0;
   logic        red_sel = 1'b0;
   logic [1:0]  atb_ena_in = 2'b00;

   logic        code_ready, pdb, bin0_red_sel, dac_ready, sat;
   logic [16:0] therm_sel;
   logic [5:0]  bin_sel;
   logic [1:0]  atb_ena;

   logic        code_ready_f, pdb_f, bin0_red_sel_f, dac_ready_f, sat_f;
   logic [16:0] therm_sel_f;
   logic [5:0]  bin_sel_f;
   logic [1:0]  atb_ena_f;

   int n_tests = 0;
   int n_fail  = 0;

   // behavioural model
   bit          m_pwr;
   int          m_wait;
   int          m_ptr;
   logic [16:0] m_therm, m_therm_fix;
   logic [5:0]  m_bin;
   logic        m_red, m_sat;
   logic [1:0]  m_atb;

   always #5 clk = ~clk;

   dac_segment_ctrl #(.SETTLE_CYCLES(SETTLE), .DEM_EN(1'b1)) dut (
      .clk(clk), .rst(rst), .enable(enable), .code(code), .code_valid(code_valid),
      .code_ready(code_ready), .red_sel(red_sel), .atb_ena_in(atb_ena_in), .pdb(pdb),
      .therm_sel(therm_sel), .bin_sel(bin_sel), .bin0_red_sel(bin0_red_sel),
      .atb_ena(atb_ena), .dac_ready(dac_ready), .sat(sat)
   );

   dac_segment_ctrl #(.SETTLE_CYCLES(SETTLE), .DEM_EN(1'b0)) dut_fix (
      .clk(clk), .rst(rst), .enable(enable), .code(code), .code_valid(code_valid),
      .code_ready(code_ready_f), .red_sel(red_sel), .atb_ena_in(atb_ena_in), .pdb(pdb_f),
      .therm_sel(therm_sel_f), .bin_sel(bin_sel_f), .bin0_red_sel(bin0_red_sel_f),
      .atb_ena(atb_ena_f), .dac_ready(dac_ready_f), .sat(sat_f)
   );

   task automatic tick();
      int cc;
      int nn;
      int bb;
      @(posedge clk);
      if (rst || !enable) begin
         m_pwr = 0; m_wait = 0; m_ptr = 0;
         m_therm = '0; m_therm_fix = '0; m_bin = '0;
         m_red = 1'b0; m_sat = 1'b0; m_atb = 2'b00;
      end else begin
         m_atb = m_pwr ? atb_ena_in : 2'b00;
         if (!m_pwr) begin
            m_pwr  = 1;
            m_wait = SETTLE;
         end else if (m_wait > 0) begin
            m_wait--;
         end else if (code_valid) begin
            cc    = int'(code);
            m_sat = (cc > 1151);
            if (cc > 1151) cc = 1151;
            nn = cc / 64;
            bb = cc % 64;
            m_therm = '0;
            m_therm_fix = '0;
            for (int k = 0; k < nn; k++) begin
               m_therm[(m_ptr + k) % 17] = 1'b1;
               m_therm_fix[k] = 1'b1;
            end
            m_ptr = (m_ptr + nn) % 17;
            m_bin = 6'(bb);
            if (red_sel) begin
               m_red = m_bin[0];
               m_bin[0] = 1'b0;
            end else begin
               m_red = 1'b0;
            end
         end
      end
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; enable = 1'b0;
      repeat (3) tick();
      n_tests += 6;
      if (pdb !== 1'b0)        begin n_fail++; $display("FAIL reset_pdb got=%b exp=0", pdb); end
      if (therm_sel !== 17'h0) begin n_fail++; $display("FAIL reset_therm got=%h exp=0", therm_sel); end
      if ({bin_sel, bin0_red_sel, sat} !== 8'h0) begin n_fail++; $display("FAIL reset_bin got=%b exp=0", {bin_sel, bin0_red_sel, sat}); end
      if (atb_ena !== 2'b00)   begin n_fail++; $display("FAIL reset_atb got=%b exp=00", atb_ena); end
      if (code_ready !== 1'b0) begin n_fail++; $display("FAIL reset_code_ready got=%b exp=0", code_ready); end
      if (dac_ready !== 1'b0)  begin n_fail++; $display("FAIL reset_dac_ready got=%b exp=0", dac_ready); end
      rst = 1'b0;
      tick();
      n_tests++;
      if ({pdb, code_ready} !== 2'b00) begin n_fail++; $display("FAIL idle_off got=%b exp=00", {pdb, code_ready}); end
   endtask

   task automatic test_power_up();
      logic       exp_cr;
      logic [5:0] exp_bin;
      logic [1:0] exp_atb;
      enable = 1'b1; code_valid = 1'b1; code = 11'd5; red_sel = 1'b0; atb_ena_in = 2'b10;
      for (int i = 1; i <= 6; i++) begin
         tick();
         exp_cr  = (i >= 5);
         exp_bin = (i >= 6) ? 6'd5 : 6'd0;
         exp_atb = (i >= 2) ? 2'b10 : 2'b00;
         n_tests += 5;
         if (pdb !== 1'b1)          begin n_fail++; $display("FAIL pu_pdb clk=%0d got=%b exp=1", i, pdb); end
         if (code_ready !== exp_cr) begin n_fail++; $display("FAIL pu_code_ready clk=%0d got=%b exp=%b", i, code_ready, exp_cr); end
         if (bin_sel !== exp_bin)   begin n_fail++; $display("FAIL pu_bin clk=%0d got=%b exp=%b", i, bin_sel, exp_bin); end
         if (therm_sel !== 17'h0)   begin n_fail++; $display("FAIL pu_therm clk=%0d got=%h exp=0", i, therm_sel); end
         if (atb_ena !== exp_atb)   begin n_fail++; $display("FAIL pu_atb clk=%0d got=%b exp=%b", i, atb_ena, exp_atb); end
      end
   endtask

   task automatic test_basic_mapping();
      code = 11'd165; red_sel = 1'b0; code_valid = 1'b1;
      tick();
      n_tests += 3;
      if (therm_sel !== 17'h00003) begin n_fail++; $display("FAIL map_therm got=%h exp=00003", therm_sel); end
      if (bin_sel !== 6'b100101)   begin n_fail++; $display("FAIL map_bin got=%b exp=100101", bin_sel); end
      if ({bin0_red_sel, sat} !== 2'b00) begin n_fail++; $display("FAIL map_red_sat got=%b exp=00", {bin0_red_sel, sat}); end
   endtask

   task automatic test_dwa_wrap();
      code = 11'd1024;
      tick();
      n_tests += 2;
      if (therm_sel !== 17'h1FFFD) begin n_fail++; $display("FAIL wrap_therm got=%h exp=1fffd", therm_sel); end
      if ($countones(therm_sel) != 16) begin n_fail++; $display("FAIL wrap_popcount got=%0d exp=16", $countones(therm_sel)); end
   endtask

   task automatic test_sat_red();
      code = 11'd2047; red_sel = 1'b1;
      tick();
      n_tests += 3;
      if (therm_sel !== 17'h1FFFF) begin n_fail++; $display("FAIL sat_therm got=%h exp=1ffff", therm_sel); end
      if (bin_sel !== 6'b111110)   begin n_fail++; $display("FAIL sat_bin got=%b exp=111110", bin_sel); end
      if ({bin0_red_sel, sat} !== 2'b11) begin n_fail++; $display("FAIL sat_red_flag got=%b exp=11", {bin0_red_sel, sat}); end
      code = 11'd64; red_sel = 1'b0;
      tick();
      n_tests += 2;
      if (therm_sel !== 17'h00002) begin n_fail++; $display("FAIL sat_ptr_hold got=%h exp=00002", therm_sel); end
      if ({bin_sel, bin0_red_sel, sat} !== 8'h0) begin n_fail++; $display("FAIL sat_clear got=%b exp=0", {bin_sel, bin0_red_sel, sat}); end
      code_valid = 1'b0; code = 11'd1151;
      tick();
      n_tests++;
      if ({therm_sel, sat} !== {17'h00002, 1'b0}) begin n_fail++; $display("FAIL idle_hold got=%h/%b exp=00002/0", therm_sel, sat); end
   endtask

   task automatic test_power_down();
      logic        exp_cr;
      logic [16:0] exp_th;
      code_valid = 1'b1;
      repeat (3) begin
         code = 11'($urandom_range(64, 1151));
         tick();
      end
      enable = 1'b0; code = 11'd700;
      tick();
      n_tests += 4;
      if (pdb !== 1'b0)         begin n_fail++; $display("FAIL pd_pdb got=%b exp=0", pdb); end
      if (therm_sel !== 17'h0)  begin n_fail++; $display("FAIL pd_therm got=%h exp=0", therm_sel); end
      if ({bin_sel, bin0_red_sel, sat} !== 8'h0) begin n_fail++; $display("FAIL pd_bin got=%b exp=0", {bin_sel, bin0_red_sel, sat}); end
      if ({code_ready, atb_ena} !== 3'b000) begin n_fail++; $display("FAIL pd_ready_atb got=%b exp=000", {code_ready, atb_ena}); end
      enable = 1'b1; code = 11'd64;
      for (int i = 1; i <= 6; i++) begin
         tick();
         exp_cr = (i >= 5);
         exp_th = (i >= 6) ? 17'h00001 : 17'h0;
         n_tests += 2;
         if (code_ready !== exp_cr) begin n_fail++; $display("FAIL pd_resettle clk=%0d got=%b exp=%b", i, code_ready, exp_cr); end
         if (therm_sel !== exp_th)  begin n_fail++; $display("FAIL pd_ptr_cleared clk=%0d got=%h exp=%h", i, therm_sel, exp_th); end
      end
   endtask

   task automatic test_random();
      logic exp_act;
      enable = 1'b1;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         rst = ($urandom_range(0, 299) == 0);
         if ($urandom_range(0, 99) < 3) enable = ~enable;
         code_valid = ($urandom_range(0, 3) != 0);
         code = ($urandom_range(0, 3) == 0) ? 11'($urandom_range(1100, 2047)) : 11'($urandom);
         red_sel = 1'($urandom);
         atb_ena_in = 2'($urandom);
         tick();
         exp_act = m_pwr && (m_wait == 0);
         n_tests += 7;
         if (pdb !== m_pwr) begin n_fail++; $display("FAIL rnd_pdb cyc=%0d got=%b exp=%b", cyc, pdb, m_pwr); end
         if ({code_ready, dac_ready} !== {exp_act, exp_act}) begin n_fail++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", cyc, {code_ready, dac_ready}, {exp_act, exp_act}); end
         if (therm_sel !== m_therm) begin n_fail++; $display("FAIL rnd_therm cyc=%0d got=%h exp=%h", cyc, therm_sel, m_therm); end
         if ({bin_sel, bin0_red_sel} !== {m_bin, m_red}) begin n_fail++; $display("FAIL rnd_bin cyc=%0d got=%b exp=%b", cyc, {bin_sel, bin0_red_sel}, {m_bin, m_red}); end
         if ({sat, atb_ena} !== {m_sat, m_atb}) begin n_fail++; $display("FAIL rnd_sat_atb cyc=%0d got=%b exp=%b", cyc, {sat, atb_ena}, {m_sat, m_atb}); end
         if (therm_sel_f !== m_therm_fix) begin n_fail++; $display("FAIL rnd_fixed_therm cyc=%0d got=%h exp=%h", cyc, therm_sel_f, m_therm_fix); end
         if ({pdb_f, code_ready_f, dac_ready_f, bin_sel_f, bin0_red_sel_f, sat_f, atb_ena_f} !==
             {m_pwr, exp_act, exp_act, m_bin, m_red, m_sat, m_atb}) begin
            n_fail++;
            $display("FAIL rnd_fixed_ctrl cyc=%0d got=%b exp=%b", cyc,
                     {pdb_f, code_ready_f, dac_ready_f, bin_sel_f, bin0_red_sel_f, sat_f, atb_ena_f},
                     {m_pwr, exp_act, exp_act, m_bin, m_red, m_sat, m_atb});
         end
      end
   endtask

   initial begin
      test_reset();
      test_power_up();
      test_basic_mapping();
      test_dwa_wrap();
      test_sat_red();
      test_power_down();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
